uart_rx_ext: RTL

Parametrised UART receiver with configurable frame format. It sits between the asynchronous serial input pin (after the synchroniser) and the word-level consumer. It is paced by the shared baud-rate tick generator, as the existing receiver is. Compared with the fixed-format receiver, it adds:
- mid-bit sampling;
- start-bit glitch rejection;
- optional parity and 1 or 2 stop bits;
- parity and framing error reporting;
- break handling.

---
 rtl/uart_rx_ext.sv | 75 +++++++
 1 files changed

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampled UART receiver with optional parity, 1/2 stop bits, glitch and break handling (in: i_clk i_reset i_rx i_bd_tick; out: o_data o_rx_done o_parity_err o_frame_err o_busy)
module uart_rx_ext #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_bd_tick,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_tick;
  logic [BW-1:0] r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic r_armed, r_perr, r_ferr, w_done, w_mid, w_end, w_par_err;
  assign w_mid = i_bd_tick && r_tick == TW'(OVERSAMPLE / 2 - 1);
  assign w_end = i_bd_tick && r_tick == TW'(OVERSAMPLE - 1);
  assign w_par_err = ^r_shift ^ i_rx ^ (PARITY == 1);
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE:  w_next = r_armed && !i_rx ? START : IDLE;
      START: w_next = w_mid ? (i_rx ? IDLE : DATA) : START;
      DATA:  w_next = w_end && r_bit == BW'(DATA_BITS - 1) ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:   w_next = w_end ? STOP : PAR;
      STOP: begin
        w_done = w_end && r_bit == BW'(STOP_BITS - 1);
        w_next = w_done ? IDLE : STOP;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_armed      <= 1'b0;
      r_tick       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      o_data       <= '0;
      o_rx_done    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_armed   <= r_state == IDLE && i_rx;
      r_tick    <= r_state == IDLE || (i_bd_tick && (w_next != r_state || r_tick == TW'(OVERSAMPLE - 1))) ? '0 : r_tick + TW'(i_bd_tick);
      r_bit     <= w_next != r_state ? '0 : r_bit + BW'(w_end && (r_state == DATA || r_state == STOP));
      r_perr    <= r_state == IDLE ? 1'b0 : r_state == PAR && w_end ? w_par_err : r_perr;
      r_ferr    <= r_state == IDLE ? 1'b0 : r_state == STOP && w_end && !i_rx ? 1'b1 : r_ferr;
      o_rx_done <= w_done;
      o_busy    <= w_next != IDLE;
      if (r_state == DATA && w_end) r_shift <= {i_rx, r_shift[DATA_BITS-1:1]};
      if (w_done) begin
        o_data       <= r_shift;
        o_parity_err <= r_perr;
        o_frame_err  <= r_ferr | !i_rx;
      end
    end
  end
endmodule
